// File: rtl/scope_pkg.sv
// Shared definitions for the oscilloscope capture path: FSM state and
// trigger-mode encodings plus the default channel geometry.
package scope_pkg;

    localparam int unsigned DATA_W_DEF       = 12;
    localparam int unsigned ADDR_W_DEF       = 10;
    localparam int unsigned DEPTH_DEF        = 640;
    localparam int unsigned PRETRIG_DEF      = 160;
    localparam int unsigned AUTO_TIMEOUT_DEF = 4096;

    // rate_sel width and the prescaler width it can address (2^(31+1) clocks max)
    localparam int unsigned RATE_W  = 5;
    localparam int unsigned PRESC_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_AUTO     = 2'd0,
        MODE_NORMAL   = 2'd1,
        MODE_SINGLE   = 2'd2,
        MODE_AUTO_ALT = 2'd3
    } mode_e;

    // Encoding 3 behaves exactly like auto
    function automatic logic mode_is_auto(input logic [1:0] m);
        return (m == 2'(MODE_AUTO)) || (m == 2'(MODE_AUTO_ALT));
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator: free-running prescaler, tick_c pulses for one
// clock whenever the low rate_sel+1 prescaler bits are all ones, i.e. once
// every 2^(rate_sel+1) clocks. A new rate_sel applies on the next match.
//   clock, reset_n : clock and asynchronous active-low reset
//   rate_sel       : log2(tick period) - 1
//   tick_c         : combinational one-cycle tick
module sample_tick_gen
    import scope_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [RATE_W-1:0] rate_sel,
    output logic              tick_c
);

    localparam int unsigned MASK_W = PRESC_W + 1;

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic [PRESC_W-1:0] mask_c;

    // Mask is built one bit wider so rate_sel = 31 yields all 32 ones
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        mask_c  = PRESC_W'((MASK_W'(1) << (32'(rate_sel) + 32'd1)) - MASK_W'(1));
        tick_c  = ((presc_q & mask_c) == mask_c);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Trigger/capture sequencer for one oscilloscope channel. Writes ADC samples
// into a circular display buffer on each sample tick, fills PRETRIG samples,
// waits for a level-crossing trigger (or auto timeout), captures the rest of
// the buffer and then freezes it for the display.
//   clock, reset_n        : clock and asynchronous active-low reset
//   rate_sel              : sample tick every 2^(rate_sel+1) clocks
//   sample_in             : ADC reading
//   trig_level/trig_slope : threshold and edge (0 rising, 1 falling)
//   mode                  : 0 auto, 1 normal, 2 single, 3 auto
//   hold                  : freezes capture while high
//   rearm, frame_done     : single-mode restart / display-read-complete pulses
//   wr_en/wr_addr/wr_data : buffer write port
//   trig_addr             : buffer address of the trigger sample
//   buf_valid             : buffer complete and stable
//   triggered             : last capture was a real trigger (0 = auto forced)
//   state                 : current FSM state
module capture_sequencer
    import scope_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned PRETRIG      = PRETRIG_DEF,
    parameter int unsigned AUTO_TIMEOUT = AUTO_TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [RATE_W-1:0] rate_sel,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        mode,
    input  logic              hold,
    input  logic              rearm,
    input  logic              frame_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              buf_valid,
    output logic              triggered,
    output logic [2:0]        state
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned TO_W   = $clog2(AUTO_TIMEOUT + 1);
    localparam int unsigned POST_N = DEPTH - PRETRIG - 1;

    state_e            state_q,     state_d;
    logic [DATA_W-1:0] samp_q,      samp_d;
    logic [DATA_W-1:0] prev_q,      prev_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              buf_valid_q, buf_valid_d;
    logic              triggered_q, triggered_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [TO_W-1:0]   to_q,        to_d;

    logic              tick_c;
    logic              capturing_c;
    logic              qtick_c;
    logic              trig_hit_c;
    logic              is_single_c;
    logic [TO_W-1:0]   to_inc_c;

    sample_tick_gen u_tick (
        .clock    (clock),
        .reset_n  (reset_n),
        .rate_sel (rate_sel),
        .tick_c   (tick_c)
    );

    // Qualified tick: accepts a sample; the write follows on the next cycle
    always_comb begin
        capturing_c = (state_q == ST_PREFILL) || (state_q == ST_ARMED) ||
                      (state_q == ST_POST);
        qtick_c     = tick_c && capturing_c && !hold;
        is_single_c = (mode == 2'(MODE_SINGLE));
    end

    // Level crossing between the previous and the freshly registered sample
    always_comb begin
        if (trig_slope) begin
            trig_hit_c = (prev_q > trig_level) && (samp_q <= trig_level);
        end else begin
            trig_hit_c = (prev_q < trig_level) && (samp_q >= trig_level);
        end
    end

    // Next-state and datapath. All counting happens in the write cycle
    // (wr_en_q = 1); a sample accepted on a tick always completes its write.
    // Ticks are never back to back, so a write cycle never carries a new tick.
    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        prev_d      = prev_q;
        wr_en_d     = qtick_c;
        wr_addr_d   = wr_addr_q;
        trig_addr_d = trig_addr_q;
        triggered_d = triggered_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        to_inc_c    = (to_q == TO_W'(AUTO_TIMEOUT)) ? to_q : to_q + TO_W'(1);

        if (qtick_c) begin
            samp_d = sample_in;
            prev_d = samp_q;
        end

        if (wr_en_q) begin
            wr_addr_d = (wr_addr_q == ADDR_W'(DEPTH - 1)) ? '0
                                                          : wr_addr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!hold) begin
                    state_d = ST_PREFILL;
                    cnt_d   = '0;
                end
            end
            ST_PREFILL: begin
                if (wr_en_q) begin
                    if (cnt_q == CNT_W'(PRETRIG - 1)) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                        to_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ARMED: begin
                if (wr_en_q) begin
                    to_d = to_inc_c;
                    if (trig_hit_c) begin
                        state_d     = ST_POST;
                        trig_addr_d = wr_addr_q;
                        triggered_d = 1'b1;
                        cnt_d       = '0;
                    end else if (mode_is_auto(mode) &&
                                 (to_inc_c == TO_W'(AUTO_TIMEOUT))) begin
                        state_d     = ST_POST;
                        trig_addr_d = wr_addr_q;
                        triggered_d = 1'b0;
                        cnt_d       = '0;
                    end
                end
            end
            ST_POST: begin
                if (POST_N == 0) begin
                    state_d = ST_DONE;
                end else if (wr_en_q) begin
                    if ((32'(cnt_q) + 32'd1) == POST_N) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                // hold masks the restart event; it is not remembered
                if (!hold && (is_single_c ? rearm : frame_done)) begin
                    state_d = ST_PREFILL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Tracks the next state so the flag falls on the same edge DONE is left
        buf_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            samp_q      <= '0;
            prev_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
            buf_valid_q <= 1'b0;
            triggered_q <= 1'b0;
            cnt_q       <= '0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            prev_q      <= prev_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            trig_addr_q <= trig_addr_d;
            buf_valid_q <= buf_valid_d;
            triggered_q <= triggered_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = samp_q;
    assign trig_addr = trig_addr_q;
    assign buf_valid = buf_valid_q;
    assign triggered = triggered_q;
    assign state     = state_q;

endmodule
